// File: rtl/led_pattern_engine.sv
// LED pattern engine: WIDTH-bit pattern stepped by a built-in prescaler.
// Modes: rotate left, rotate right, ping-pong, fill/empty bar.
module led_pattern_engine #(
    parameter int WIDTH   = 8,
    parameter int DIV_MAX = 25000000,
    parameter int DIV_W   = 25
) (
    input  logic             clk_50M,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             wrap
);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;
    typedef enum logic {PH_FILL, PH_EMPTY} phase_e;

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV_MAX - 1);
    localparam logic [WIDTH-1:0] P_ONE    = WIDTH'(1);
    localparam logic [WIDTH-1:0] P_MSB    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] P_ALL    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] P_ZERO   = '0;

    logic [WIDTH-1:0] q_q, q_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    dir_e             dir_q, dir_d;
    phase_e           phase_q, phase_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic             step;
    logic             period_end;

    function automatic logic [WIDTH-1:0] init_pat(input logic [1:0] m);
        logic [WIDTH-1:0] p;
        unique case (m)
            2'd0:    p = P_ONE;
            2'd1:    p = P_MSB;
            2'd2:    p = P_ONE;
            default: p = P_ZERO;
        endcase
        return p;
    endfunction

    always_comb begin
        q_d        = q_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        dir_d      = dir_q;
        phase_d    = phase_q;
        tick_d     = 1'b0;
        wrap_d     = 1'b0;
        step       = 1'b0;
        period_end = 1'b0;

        if (mode != mode_q) begin
            // reload discards any step that falls due in this cycle
            q_d     = init_pat(mode);
            cnt_d   = '0;
            mode_d  = mode;
            dir_d   = DIR_UP;
            phase_d = PH_FILL;
        end else if (enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                step  = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end

            if (step) begin
                unique case (mode_q)
                    2'd0: begin
                        q_d        = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                        period_end = q_q[WIDTH-1];
                    end
                    2'd1: begin
                        q_d        = {q_q[0], q_q[WIDTH-1:1]};
                        period_end = q_q[0];
                    end
                    2'd2: begin
                        if (dir_q == DIR_UP) begin
                            q_d = q_q << 1;
                            if (q_d == P_MSB) dir_d = DIR_DOWN;
                        end else begin
                            q_d = q_q >> 1;
                            if (q_d == P_ONE) begin
                                dir_d      = DIR_UP;
                                period_end = 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (phase_q == PH_FILL) begin
                            q_d = {q_q[WIDTH-2:0], 1'b1};
                            if (q_d == P_ALL) phase_d = PH_EMPTY;
                        end else begin
                            q_d = q_q << 1;
                            if (q_d == P_ZERO) begin
                                phase_d    = PH_FILL;
                                period_end = 1'b1;
                            end
                        end
                    end
                endcase
                tick_d = 1'b1;
                wrap_d = period_end;
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            q_q     <= init_pat(mode);
            cnt_q   <= '0;
            mode_q  <= mode;
            dir_q   <= DIR_UP;
            phase_q <= PH_FILL;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign q    = q_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Bench for led_pattern_engine (WIDTH=8, DIV_MAX=4): step tables
// checked through a scoreboard, plus enable-freeze and reload sequences.
module tb_led_pattern_engine;

    logic       clk_50M = 1'b0;
    logic       reset   = 1'b1;
    logic       enable  = 1'b1;
    logic [1:0] mode    = 2'd0;
    logic [7:0] q;
    logic       tick;
    logic       wrap;

    led_pattern_engine #(
        .WIDTH  (8),
        .DIV_MAX(4),
        .DIV_W  (4)
    ) dut (
        .clk_50M(clk_50M),
        .reset  (reset),
        .enable (enable),
        .mode   (mode),
        .q      (q),
        .tick   (tick),
        .wrap   (wrap)
    );

    always #5 clk_50M = ~clk_50M;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] q;
        logic       wrap;
    } vec_t;

    typedef struct packed {
        logic [7:0] q;
        logic       wrap;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic [1:0] cur_mode = 2'd0;

    // bit 8 marks the step that must raise wrap
    logic [8:0] seq0 [10] = '{9'h002, 9'h004, 9'h008, 9'h010, 9'h020,
                              9'h040, 9'h080, 9'h101, 9'h002, 9'h004};
    logic [8:0] seq1 [9]  = '{9'h040, 9'h020, 9'h010, 9'h008, 9'h004,
                              9'h002, 9'h001, 9'h180, 9'h040};
    logic [8:0] seq2 [14] = '{9'h002, 9'h004, 9'h008, 9'h010, 9'h020,
                              9'h040, 9'h080, 9'h040, 9'h020, 9'h010,
                              9'h008, 9'h004, 9'h002, 9'h101};
    logic [8:0] seq3 [17] = '{9'h001, 9'h003, 9'h007, 9'h00F, 9'h01F,
                              9'h03F, 9'h07F, 9'h0FF, 9'h0FE, 9'h0FC,
                              9'h0F8, 9'h0F0, 9'h0E0, 9'h0C0, 9'h080,
                              9'h100, 9'h001};
    logic [7:0] init_tab [4] = '{8'h01, 8'h80, 8'h01, 8'h00};

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want,
                     $time);
        end
    endtask

    task automatic clk1();
        @(posedge clk_50M);
        #1;
    endtask

    function automatic void add(input logic [1:0] m, input logic [8:0] v);
        vec_t e;
        e.mode = m;
        e.q    = v[7:0];
        e.wrap = v[8];
        vt.push_back(e);
    endfunction

    task automatic drain();
        int   c;
        exp_t e;
        c = 0;
        while (sb.size() > 0) begin
            clk1();
            c++;
            if (tick) begin
                e = sb.pop_front();
                chk("step_q", 32'(q), 32'(e.q));
                chk("step_wrap", 32'(wrap), 32'(e.wrap));
                chk("step_gap", 32'(c), 32'd4);
                c = 0;
            end else begin
                chk("idle_wrap", 32'(wrap), 32'd0);
                if (c > 8) begin
                    total++;
                    bad++;
                    $display("FAIL tick_timeout: got no tick want tick");
                    sb.delete();
                end
            end
        end
    endtask

    task automatic switch_mode(input logic [1:0] m);
        mode = m;
        clk1();
        chk("reload_q", 32'(q), 32'(init_tab[m]));
        chk("reload_tick", 32'(tick), 32'd0);
        cur_mode = m;
    endtask

    task automatic run_table(input int lo, input int hi);
        exp_t e;
        for (int i = lo; i < hi; i++) begin
            if (vt[i].mode != cur_mode) begin
                drain();
                switch_mode(vt[i].mode);
            end
            e.q    = vt[i].q;
            e.wrap = vt[i].wrap;
            sb.push_back(e);
        end
        drain();
    endtask

    initial begin
        foreach (seq0[i]) add(2'd0, seq0[i]);
        foreach (seq1[i]) add(2'd1, seq1[i]);
        foreach (seq2[i]) add(2'd2, seq2[i]);
        foreach (seq2[i]) add(2'd2, seq2[i]);
        foreach (seq3[i]) add(2'd3, seq3[i]);
        for (int i = 0; i < 9; i++) add(2'd2, seq2[i]);

        reset = 1'b1;
        mode  = 2'd0;
        clk1();
        clk1();
        chk("reset_q", 32'(q), 32'h01);
        chk("reset_tick", 32'(tick), 32'd0);
        chk("reset_wrap", 32'(wrap), 32'd0);
        reset = 1'b0;

        run_table(0, 10);

        // freeze mid-count at q=0x04
        for (int i = 0; i < 2; i++) begin
            clk1();
            chk("pre_freeze_q", 32'(q), 32'h04);
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            clk1();
            chk("freeze_q", 32'(q), 32'h04);
            chk("freeze_tick", 32'(tick), 32'd0);
        end
        enable = 1'b1;
        clk1();
        chk("resume1_q", 32'(q), 32'h04);
        chk("resume1_tick", 32'(tick), 32'd0);
        clk1();
        chk("resume2_q", 32'(q), 32'h08);
        chk("resume2_tick", 32'(tick), 32'd1);

        run_table(10, vt.size());

        // ping-pong heading down at 0x20; switch when a step is due
        for (int i = 0; i < 3; i++) clk1();
        chk("pre_switch_q", 32'(q), 32'h20);
        mode = 2'd3;
        clk1();
        chk("switch_q", 32'(q), 32'h00);
        chk("switch_tick", 32'(tick), 32'd0);
        for (int i = 0; i < 3; i++) begin
            clk1();
            chk("bar_wait_q", 32'(q), 32'h00);
            chk("bar_wait_tick", 32'(tick), 32'd0);
        end
        clk1();
        chk("bar_first_q", 32'(q), 32'h01);
        chk("bar_first_tick", 32'(tick), 32'd1);
        chk("bar_first_wrap", 32'(wrap), 32'd0);

        for (int i = 0; i < 2; i++) clk1();
        reset = 1'b1;
        mode  = 2'd1;
        clk1();
        chk("midreset_q", 32'(q), 32'h80);
        chk("midreset_tick", 32'(tick), 32'd0);
        chk("midreset_wrap", 32'(wrap), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk1();
            chk("post_reset_q", 32'(q), 32'h80);
        end
        clk1();
        chk("post_reset_step_q", 32'(q), 32'h40);
        chk("post_reset_step_tick", 32'(tick), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
